// File: rtl/edge_detector.sv
// Rising/falling edge strobes for a slow, clock-like input sampled in the fast i_clk domain.
// Optional EDGE_DETECTOR_SYNC_EN adds a 2-flop synchronizer and fully registered strobes.
`timescale 1ns/1ps

module edge_detector #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_slow_clk,
  output logic o_rising_edge,
  output logic o_falling_edge
);

`ifdef EDGE_DETECTOR_SYNC_EN

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Strobes register the sync2/prev comparison, so they land 3 edges after the input edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
      prev_q  <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= i_slow_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign o_rising_edge  = rise_q;
  assign o_falling_edge = fall_q;

`else

  logic prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= INIT_LEVEL;
    end else begin
      prev_q <= i_slow_clk;
    end
  end

  // Reset gates the strobes so they drop the instant reset asserts, even mid-pulse.
  assign o_rising_edge  = i_rst_n & i_slow_clk & ~prev_q;
  assign o_falling_edge = i_rst_n & ~i_slow_clk & prev_q;

`endif

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector (combinational-strobe build, INIT_LEVEL = 0).
`timescale 1ns/1ps

module tb_edge_detector;

  localparam logic InitLevel = 1'b0;

  logic clk;
  logic rst_n;
  logic slow;
  logic rise;
  logic fall;

  int vectors;
  int miscompares;

  edge_detector #(
    .INIT_LEVEL(InitLevel)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_slow_clk    (slow),
    .o_rising_edge (rise),
    .o_falling_edge(fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the levels of the slow input seen at each clock edge since reset.
  // A strobe means "the input now differs from the last level seen (or INIT_LEVEL if none)".
  logic hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist.delete();
    else        hist.push_back(slow);
  end

  function automatic logic last_seen();
    if (hist.size() == 0) return InitLevel;
    return hist[hist.size()-1];
  endfunction

  task automatic check(input string name, input logic er, input logic ef);
    vectors++;
    if (rise !== er || fall !== ef) begin
      miscompares++;
      $display("FAIL %s @%0t: rise=%b fall=%b, required rise=%b fall=%b",
               name, $time, rise, fall, er, ef);
    end
  endtask

  task automatic check_model(input string name);
    logic er, ef;
    er = 1'b0;
    ef = 1'b0;
    if (rst_n && slow != last_seen()) begin
      er = slow;
      ef = ~slow;
    end
    check(name, er, ef);
  endtask

  typedef struct {
    logic       rst_n;
    logic       slow;
    logic [1:0] exp_a;  // {rise, fall} 1 ns after driving at the falling clock edge
    logic [1:0] exp_b;  // {rise, fall} 1 ns after the following rising clock edge
  } vec_t;

  vec_t tbl[11];

  int rise_cnt;
  int fall_cnt;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    slow        = 1'b0;

    tbl[0]  = '{1'b0, 1'b1, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 1'b1, 2'b10, 2'b00};  // release with input high vs INIT_LEVEL=0
    tbl[2]  = '{1'b1, 1'b1, 2'b00, 2'b00};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 2'b00};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 1'b1, 2'b10, 2'b00};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 2'b00};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 1'b1, 2'b10, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 1'b1, 2'b10, 2'b00};

    // Reset held for 16 cycles while the input toggles every half cycle.
    for (int i = 0; i < 32; i++) begin
      if (i[0]) @(posedge clk);
      else      @(negedge clk);
      slow = ~slow;
      #1;
      check("reset_hold", 1'b0, 1'b0);
    end

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      slow  = tbl[i].slow;
      #1;
      check($sformatf("tbl%0d_a", i), tbl[i].exp_a[1], tbl[i].exp_a[0]);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_b", i), tbl[i].exp_b[1], tbl[i].exp_b[0]);
    end

    // 25 MHz slow clock against 100 MHz fast clock for 100 slow periods.
    slow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 100; p++) begin
      for (int h = 0; h < 2; h++) begin
        slow = ~slow;
        #1;
        if (slow) check("rise_detect", 1'b1, 1'b0);
        else      check("fall_detect", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pulse_end", 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("between", 1'b0, 1'b0);
        @(negedge clk);
      end
    end

    // Steady-high input after release: exactly one rising strobe.
    rst_n = 1'b0;
    slow  = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    rise_cnt = 0;
    fall_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      rise_cnt += int'(rise);
      fall_cnt += int'(fall);
      @(posedge clk);
      #1;
      rise_cnt += int'(rise);
      fall_cnt += int'(fall);
      @(negedge clk);
    end
    vectors++;
    if (rise_cnt != 1 || fall_cnt != 0) begin
      miscompares++;
      $display("FAIL steady_high: rise samples=%0d fall samples=%0d, required 1 and 0",
               rise_cnt, fall_cnt);
    end

    // Reset asserted mid-pulse, then released with the input still high.
    slow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    slow = 1'b1;
    #1;
    check("midpulse_pre", 1'b1, 1'b0);
    rst_n = 1'b0;
    #0.5;
    check("midpulse_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midpulse_release", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("midpulse_end", 1'b0, 1'b0);

    // Randomized input and occasional reset, checked against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) slow = ~slow;
      if ($urandom_range(0, 31) == 0) rst_n = ~rst_n;
      #1;
      check_model("rand_neg");
      @(posedge clk);
      #1;
      check_model("rand_pos");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_detector.md
Name: edge_detector

Overview:
- Detects rising and falling transitions of a slow, clock-like input (`i_slow_clk`) in the fast `i_clk` domain.
- Emits single-pulse strobes on `o_rising_edge` and `o_falling_edge`.
- Used by the SPI controller to derive SCLK edge strobes from a divided clock.
- Outputs are combinational against a registered copy of the previous sample, so a strobe is visible immediately after the slow edge. It is not delayed to the next `i_clk` rising edge.

Parameters:
- INIT_LEVEL, 1'b0, value loaded into the previous-sample register during reset; it is the assumed slow-clock level at reset release.

Ports:
- i_clk  input  1  fast system clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_slow_clk  input  1  slow signal whose edges are detected; driven from logic synchronous to `i_clk`; must stay stable for at least one `i_clk` period between transitions.
- o_rising_edge  output  1  high while `i_slow_clk`=1 and previous sample=0.
- o_falling_edge  output  1  high while `i_slow_clk`=0 and previous sample=1.

Behaviour:
- Clock and reset: one clock, `i_clk`. Reset `i_rst_n` is asynchronous and active-low.
- State: a 1-bit register `prev`.
  - `i_rst_n`=0 loads `prev`=INIT_LEVEL asynchronously.
  - Otherwise `prev` <= `i_slow_clk` on every `i_clk` rising edge.
- o_rising_edge = i_rst_n & i_slow_clk & ~prev.
- o_falling_edge = i_rst_n & ~i_slow_clk & prev.
- Both outputs are 0 while `i_rst_n`=0, regardless of `i_slow_clk`.
- Latency: the strobe asserts combinationally as soon as `i_slow_clk` changes. No `i_clk` edge is required.
- Pulse width: the strobe deasserts at the next `i_clk` rising edge, when `prev` catches up. It lasts from the slow edge to that clock edge; if the slow edge coincides with an `i_clk` falling edge, that is half an `i_clk` period.
- Mutual exclusion: the two outputs are never high simultaneously.
- Steady input: no strobes.
- Glitch rule: if `i_slow_clk` toggles and returns before any `i_clk` rising edge, a strobe appears for the glitch duration. The input contract forbids this.
- Reset release: the first strobe reflects `i_slow_clk` versus INIT_LEVEL.
  - INIT_LEVEL=0 with `i_slow_clk`=1 at release gives an immediate rising strobe until the next `i_clk` rising edge.
- Reset mid-pulse: outputs drop to 0 immediately and `prev` returns to INIT_LEVEL.

Optional Feature:
- Macro: EDGE_DETECTOR_SYNC_EN.
- When defined:
  - `i_slow_clk` passes through a 2-flop synchronizer (reset to INIT_LEVEL) before the edge logic.
  - `prev` samples the synchronizer output.
  - Outputs become fully registered: each strobe is exactly one `i_clk` cycle wide.
  - Strobes assert 3 `i_clk` rising edges after the input edge.
- When undefined: the combinational behaviour above, with zero-latency strobes.
- Default build is undefined.

Test Plan:
- Reset: `i_rst_n`=0 for 16 `i_clk` cycles, toggling `i_slow_clk` -> both outputs 0 throughout.
- Rising detection: `i_clk` 100 MHz (period 10 ns), `i_slow_clk` 25 MHz (toggles every 20 ns, aligned to `i_clk` falling edges). Check 1 ns after each slow rising edge -> o_rising_edge=1, o_falling_edge=0, held for 100 consecutive periods.
- Falling detection: same clocks, 1 ns after each slow falling edge -> o_rising_edge=0, o_falling_edge=1, for 100 periods.
- Pulse termination: 1 ns after the first `i_clk` rising edge following a slow edge -> both outputs 0; at most 1 output is ever high.
- Steady input: `i_slow_clk` held at 1 for 50 cycles after release -> exactly one rising strobe (from INIT_LEVEL=0), then both 0.
- Reset mid-pulse: assert `i_rst_n`=0 1 ns after a slow rising edge -> o_rising_edge falls to 0 within the same ns; after release with `i_slow_clk`=1 -> rising strobe reappears until the next `i_clk` rising edge.
